// File: rtl/quotient_bcd_converter.sv
// Converts an 8-bit divider quotient to three packed BCD digits using a
// sequential double-dabble (one shift-and-adjust step per clock).
module quotient_bcd_converter (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        finish_i,
   input  logic [8:0]  quotient_i,
   input  logic        bcd_ready_i,
   output logic        busy_o,
   output logic        bcd_valid_o,
   output logic [11:0] bcd_o,
   output logic        div_zero_o,
   output logic        overrun_o
);

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] acc_q, acc_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        dz_q, dz_d;
   logic        ovr_q, ovr_d;
   logic [11:0] acc_adj;

   function automatic logic [3:0] dabble(input logic [3:0] digit);
      return (digit >= 4'd5) ? digit + 4'd3 : digit;
   endfunction

   // Hundreds never exceeds 2 for an 8-bit input, so acc_adj[11] is always 0.
   assign acc_adj = {dabble(acc_q[11:8]), dabble(acc_q[7:4]), dabble(acc_q[3:0])};

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      dz_d    = dz_q;
      ovr_d   = finish_i && (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (finish_i) begin
               if (quotient_i[8]) begin
                  bcd_d   = 12'h000;
                  dz_d    = 1'b1;
                  state_d = StDone;
               end else begin
                  bin_d   = quotient_i[7:0];
                  acc_d   = 12'h000;
                  cnt_d   = 3'd0;
                  state_d = StConv;
               end
            end
         end
         StConv: begin
            {acc_d, bin_d} = {acc_adj[10:0], bin_q, 1'b0};
            cnt_d          = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               bcd_d   = {acc_adj[10:0], bin_q[7]};
               dz_d    = 1'b0;
               state_d = StDone;
            end
         end
         StDone: begin
            if (bcd_ready_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         bin_q   <= 8'h00;
         acc_q   <= 12'h000;
         bcd_q   <= 12'h000;
         cnt_q   <= 3'd0;
         dz_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         dz_q    <= dz_d;
         ovr_q   <= ovr_d;
      end
   end

   assign busy_o      = (state_q == StConv);
   assign bcd_valid_o = (state_q == StDone);
   assign bcd_o       = bcd_q;
   assign div_zero_o  = dz_q;
   assign overrun_o   = ovr_q;

endmodule
